// File: rtl/tiny_cpu.sv
// tiny_cpu: single-cycle 8-bit accumulator datapath (A, B, Result) executing one 12-bit instruction per clock.
// Define TINY_CPU_EXT_OPS_EN to enable SUB/SHL/AND/OR/NOT/MVA; otherwise those opcodes behave as NOP.
module tiny_cpu (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [11:0] In,
  output logic [7:0]  Result,
  output logic [7:0]  RegA,
  output logic [7:0]  RegB
);

  localparam logic [3:0] OP_CLR = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_MVB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
`ifdef TINY_CPU_EXT_OPS_EN
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1100;
  localparam logic [3:0] OP_MVA = 4'b1101;
`endif

  logic [3:0] opcode;
  logic [7:0] imm;
  logic [7:0] reg_a, reg_b, res;
  logic [7:0] a_nxt, b_nxt, r_nxt;

  assign opcode = In[11:8];
  assign imm    = In[7:0];

  always_comb begin
    a_nxt = reg_a;
    b_nxt = reg_b;
    r_nxt = res;
    case (opcode)
      OP_CLR: begin
        a_nxt = 8'h00;
        b_nxt = 8'h00;
        r_nxt = 8'h00;
      end
      OP_LDA: a_nxt = imm;
      OP_LDB: b_nxt = imm;
      OP_MVB: b_nxt = res;
      OP_ADD: r_nxt = reg_a + reg_b;
      OP_SHR: r_nxt = {1'b0, reg_a[7:1]};
      OP_XOR: r_nxt = reg_a ^ reg_b;
      OP_CMP: begin
        if (reg_a == reg_b)     r_nxt = 8'h01;
        else if (reg_a > reg_b) r_nxt = 8'h02;
        else                    r_nxt = 8'h04;
      end
`ifdef TINY_CPU_EXT_OPS_EN
      OP_SUB: r_nxt = reg_a - reg_b;
      OP_SHL: r_nxt = {reg_a[6:0], 1'b0};
      OP_AND: r_nxt = reg_a & reg_b;
      OP_OR:  r_nxt = reg_a | reg_b;
      OP_NOT: r_nxt = ~reg_a;
      OP_MVA: a_nxt = res;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      reg_a <= 8'h00;
      reg_b <= 8'h00;
      res   <= 8'h00;
    end else begin
      reg_a <= a_nxt;
      reg_b <= b_nxt;
      res   <= r_nxt;
    end
  end

  assign RegA   = reg_a;
  assign RegB   = reg_b;
  assign Result = res;

endmodule

// File: tb/tb_tiny_cpu.sv
// Directed bench for tiny_cpu; expectations follow TINY_CPU_EXT_OPS_EN when it is defined.
module tb_tiny_cpu;

`ifdef TINY_CPU_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        Clk;
  logic        Rst_n;
  logic [11:0] In;
  logic [7:0]  Result, RegA, RegB;

  int tests;
  int fails;

  typedef struct {
    logic [11:0] instr;
    int          hold;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  r;
  } vec_t;

  vec_t vecs[$];

  tiny_cpu dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .In     (In),
    .Result (Result),
    .RegA   (RegA),
    .RegB   (RegB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] sel(input logic [7:0] ext_v, input logic [7:0] base_v);
    return EXT ? ext_v : base_v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic check3(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    check({nm, ".A"}, RegA, a);
    check({nm, ".B"}, RegB, b);
    check({nm, ".R"}, Result, r);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // instr, hold, A, B, Result after the instruction has been held for 'hold' edges
    vecs.push_back('{12'h107, 4, 8'h07, 8'h00, 8'h00});
    vecs.push_back('{12'h208, 4, 8'h07, 8'h08, 8'h00});
    vecs.push_back('{12'h400, 4, 8'h07, 8'h08, 8'h0F});
    vecs.push_back('{12'h900, 4, 8'h07, 8'h08, 8'h0F});
    vecs.push_back('{12'hB00, 4, 8'h07, 8'h08, 8'h04});
    vecs.push_back('{12'h600, 4, 8'h07, 8'h08, 8'h03});
    vecs.push_back('{12'h300, 4, 8'h07, 8'h03, 8'h03});
    vecs.push_back('{12'h1FF, 1, 8'hFF, 8'h03, 8'h03});
    vecs.push_back('{12'h2FF, 1, 8'hFF, 8'hFF, 8'h03});
    vecs.push_back('{12'hB00, 2, 8'hFF, 8'hFF, 8'h01});
    vecs.push_back('{12'h202, 1, 8'hFF, 8'h02, 8'h01});
    vecs.push_back('{12'h600, 1, 8'hFF, 8'h02, 8'h7F});
    vecs.push_back('{12'h455, 1, 8'hFF, 8'h02, 8'h01});
    vecs.push_back('{12'h109, 1, 8'h09, 8'h02, 8'h01});
    vecs.push_back('{12'h203, 1, 8'h09, 8'h03, 8'h01});
    vecs.push_back('{12'hB77, 1, 8'h09, 8'h03, 8'h02});
    vecs.push_back('{12'hE12, 2, 8'h09, 8'h03, 8'h02});
    vecs.push_back('{12'hFFF, 2, 8'h09, 8'h03, 8'h02});
    vecs.push_back('{12'h400, 1, 8'h09, 8'h03, 8'h0C});
    vecs.push_back('{12'h100, 1, 8'h00, 8'h03, 8'h0C});
    vecs.push_back('{12'h201, 1, 8'h00, 8'h01, 8'h0C});
    vecs.push_back('{12'h500, 2, 8'h00, 8'h01, sel(8'hFF, 8'h0C)});
    vecs.push_back('{12'h181, 1, 8'h81, 8'h01, sel(8'hFF, 8'h0C)});
    vecs.push_back('{12'h700, 2, 8'h81, 8'h01, sel(8'h02, 8'h0C)});
    vecs.push_back('{12'h800, 1, 8'h81, 8'h01, sel(8'h01, 8'h0C)});
    vecs.push_back('{12'hA00, 1, 8'h81, 8'h01, sel(8'h81, 8'h0C)});
    vecs.push_back('{12'hC00, 1, 8'h81, 8'h01, sel(8'h7E, 8'h0C)});
    vecs.push_back('{12'hD00, 1, sel(8'h7E, 8'h81), 8'h01, sel(8'h7E, 8'h0C)});
    vecs.push_back('{12'h900, 1, sel(8'h7E, 8'h81), 8'h01, sel(8'h7F, 8'h80)});
    vecs.push_back('{12'h300, 1, sel(8'h7E, 8'h81), sel(8'h7F, 8'h80), sel(8'h7F, 8'h80)});

    // reset asserted with a live instruction on In: registers stay 0
    Rst_n = 1'b0;
    In    = 12'h1FF;
    #1;
    check3("rst_async", 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge Clk);
    #1;
    check3("rst_held", 8'h00, 8'h00, 8'h00);

    // release with CLR: first edge executes it, outputs stay 0
    @(negedge Clk);
    In    = 12'h000;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check3("rst_rel_clr", 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      In = vecs[i].instr;
      repeat (vecs[i].hold) @(posedge Clk);
      #1;
      check3($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r);
    end

    // no combinational path from In to the outputs
    @(negedge Clk);
    In = 12'h000;
    #2;
    check3("no_comb", sel(8'h7E, 8'h81), sel(8'h7F, 8'h80), sel(8'h7F, 8'h80));

    // reset between edges with nonzero registers
    In = 12'hE00;
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    check3("rst_mid", 8'h00, 8'h00, 8'h00);
    @(negedge Clk);
    In = 12'h133;
    @(posedge Clk);
    #1;
    check3("rst_mid_held", 8'h00, 8'h00, 8'h00);

    // first edge after release executes the pending instruction
    @(negedge Clk);
    In    = 12'h15A;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check3("rel_lda", 8'h5A, 8'h00, 8'h00);

    @(negedge Clk);
    In = 12'h211;
    @(posedge Clk);
    @(negedge Clk);
    In = 12'h400;
    @(posedge Clk);
    #1;
    check3("pre_clr", 8'h5A, 8'h11, 8'h6B);
    @(negedge Clk);
    In = 12'h0AB;
    @(posedge Clk);
    #1;
    check3("clr", 8'h00, 8'h00, 8'h00);

    // MVA then a reader of A: held MVA is idempotent, the following ADD sees the moved value
    if (EXT) begin
      @(negedge Clk); In = 12'h110;
      @(negedge Clk); In = 12'h220;
      @(negedge Clk); In = 12'h400;
      @(negedge Clk); In = 12'hD00;
      repeat (3) @(posedge Clk);
      #1;
      check3("mva_hold", 8'h30, 8'h20, 8'h30);
      @(negedge Clk); In = 12'h400;
      @(posedge Clk);
      #1;
      check3("mva_add", 8'h30, 8'h20, 8'h50);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tiny_cpu.md
# tiny_cpu

Single-cycle 8-bit accumulator-style datapath: two general registers (A, B) and a Result register, driven by a 12-bit instruction word presented on `In` each clock. The block is the execution core of the MiniCPU design; instruction sequencing is external, and the three architectural registers are exported for observation.

## Interface
- No parameters.
- `Clk`  input  1  sole clock; all state updates on rising edge.
- `Rst_n`  input  1  asynchronous, active-low reset.
- `In`  input  12  instruction: `In[11:8]` opcode, `In[7:0]` immediate.
- `Result`  output  8  Result register.
- `RegA`  output  8  register A contents.
- `RegB`  output  8  register B contents.

## Operation
- Opcodes; all arithmetic unsigned, 8-bit, truncated; unlisted registers hold:
  - `0000` CLR: A, B and Result set to 0.
  - `0001` LDA: A set to imm.
  - `0010` LDB: B set to imm.
  - `0011` MVB: B set to Result.
  - `0100` ADD: Result set to (A+B) mod 256; carry discarded.
  - `0101` SUB: Result set to (A−B) mod 256.
  - `0110` SHR: Result set to A>>1, logical, MSB filled with 0.
  - `0111` SHL: Result set to A<<1, LSB filled with 0.
  - `1000` AND: Result set to A&B.
  - `1001` XOR: Result set to A^B.
  - `1010` OR: Result set to A|B.
  - `1011` CMP: Result set to 8'h01 if A==B, 8'h02 if A>B, 8'h04 if A<B.
  - `1100` NOT: Result set to ~A.
  - `1101` MVA: A set to Result.
  - `1110`, `1111`: NOP; all registers hold.
- Immediate is ignored by all opcodes except LDA/LDB.
- Operands are read from the register values before the edge. MVB/MVA use the pre-edge Result.
- Every instruction is idempotent when held on `In` for several consecutive edges. The only exception is MVA followed by an op that reads A.
- `RegA`, `RegB` and `Result` are direct register outputs, with no combinational path from `In`.

## Timing
- Reset asserted: A, B and Result are 0 immediately, independent of `Clk`. Reset held: all registers stay 0 regardless of `In`.
- Reset release: the first rising edge with `Rst_n`=1 executes the instruction on `In`.
- Latency: one cycle. The instruction is sampled at a rising edge, and its effect is visible on the outputs after that edge.
- `In` must be stable around the rising edge. It may change arbitrarily between edges.
- Reset asserted mid-sequence: state is lost and all outputs go to 0.

## Configuration
- `TINY_CPU_EXT_OPS_EN` defined: full opcode set as above.
- `TINY_CPU_EXT_OPS_EN` undefined: SUB, SHL, AND, OR, NOT and MVA (`0101`, `0111`, `1000`, `1010`, `1100`, `1101`) decode as NOP. The remaining opcodes are unchanged.

## Test plan
- Reset then CLR: all outputs 0. Deassert reset with `In`=12'h000: outputs remain 0.
- Main sequence: LDA 8'h07, LDB 8'h08, ADD, XOR, CMP, SHR, MVB, each held for about 4 clocks. Required values:
  - Result=8'h0F after ADD and after XOR.
  - Result=8'h04 after CMP.
  - Result=8'h03 after SHR.
  - B=8'h03 after MVB.
  - Final: A=8'h07, B=8'h03, Result=8'h03.
- Overflow: A=8'hFF, B=8'h02, ADD gives Result=8'h01. SUB with A=8'h00, B=8'h01 gives 8'hFF. SHL of 8'h81 gives 8'h02.
- CMP: equal operands 8'h01; A=8'h09, B=8'h03 gives 8'h02.
- Async reset: assert `Rst_n` low between clock edges with nonzero registers. All outputs go to 0 before the next edge.
- Macro off: opcodes `0101`/`0111`/`1000`/`1010`/`1100`/`1101` leave A, B and Result unchanged. Opcodes `1110`/`1111` are NOP in both builds.
